// File: rtl/coherence_bus_arbiter.sv
// coherence_bus_arbiter: round-robin owner selection for a shared coherence bus
// between NUM_CACHES L1 requesters and one L2 port (index MEM_PORT).
// A transaction is GRANT (request on the bus) -> WAIT_L2 (L2 owns the bus)
// -> RELEASE (wait for the master to withdraw) -> IDLE.
// Optional feature: define ARB_TIMEOUT_EN to build the WAIT_L2 watchdog
// (sticky timeout_err); when undefined, WAIT_L2 waits indefinitely.
module coherence_bus_arbiter #(
    parameter int NUM_CACHES = 4,
    parameter int MSG_BITS = 4,
    parameter logic [MSG_BITS-1:0] NO_REQ = '0,
    parameter logic [MSG_BITS-1:0] DONE_MSG = MSG_BITS'(9),
    parameter int TIMEOUT_CYCLES = 256,
    localparam int MEM_PORT = NUM_CACHES,
    localparam int CTRL_W = ($clog2(NUM_CACHES + 1) > 1) ? $clog2(NUM_CACHES + 1) : 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_CACHES*MSG_BITS-1:0] cache2bus_msg,
    input  logic [MSG_BITS-1:0]            l2_msg,
    output logic [CTRL_W-1:0]              bus_control,
    output logic                           bus_en,
    output logic [NUM_CACHES-1:0]          curr_master,
    output logic                           req_ready,
    output logic                           timeout_err
);

    localparam int IDX_W = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        WAIT_L2 = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   rr_ptr_reg;
    logic [IDX_W-1:0]   master_idx_reg;

    logic [NUM_CACHES-1:0] req_vec;
    logic [NUM_CACHES-1:0] winner_onehot;
    logic [IDX_W-1:0]      winner;
    logic                  any_req;
    logic [MSG_BITS-1:0]   master_msg;
    logic                  master_req;
    logic [IDX_W-1:0]      next_ptr;
    logic                  l2_done;

    // Per-cache request flags and one-hot decode of the selected winner.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CACHES; gi++) begin : g_req
            assign req_vec[gi]       = (cache2bus_msg[gi*MSG_BITS +: MSG_BITS] != NO_REQ);
            assign winner_onehot[gi] = (winner == IDX_W'(gi));
        end
    endgenerate

    assign any_req    = |req_vec;
    assign master_msg = cache2bus_msg[master_idx_reg*MSG_BITS +: MSG_BITS];
    assign master_req = (master_msg != NO_REQ);
    assign l2_done    = (l2_msg == DONE_MSG);

    // Round-robin search: first requester at or above rr_ptr, wrapping to 0.
    always_comb begin
        winner = '0;
        for (int k = NUM_CACHES - 1; k >= 0; k--) begin
            if (req_vec[(int'(rr_ptr_reg) + k) % NUM_CACHES]) begin
                winner = IDX_W'((int'(rr_ptr_reg) + k) % NUM_CACHES);
            end
        end
    end

    // Pointer moves just past the master once its transaction fully releases.
    always_comb begin
        next_ptr = '0;
        if (int'(master_idx_reg) < NUM_CACHES - 1) begin
            next_ptr = master_idx_reg + IDX_W'(1);
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd_cnt_reg;
    logic        timeout_err_reg;
    assign timeout_err = timeout_err_reg;
`else
    assign timeout_err = 1'b0;
`endif

    // Arbitration FSM with all bus-facing outputs registered alongside the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            rr_ptr_reg     <= '0;
            master_idx_reg <= '0;
            bus_control    <= '0;
            bus_en         <= 1'b0;
            curr_master    <= '0;
            req_ready      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wd_cnt_reg      <= '0;
            timeout_err_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    bus_control <= '0;
                    bus_en      <= 1'b0;
                    curr_master <= '0;
                    req_ready   <= 1'b0;
                    if (any_req) begin
                        state_reg      <= GRANT;
                        master_idx_reg <= winner;
                        bus_control    <= CTRL_W'(winner);
                        bus_en         <= 1'b1;
                        curr_master    <= winner_onehot;
                        req_ready      <= 1'b1;
                    end
                end
                GRANT: begin
                    req_ready <= 1'b0;
                    if (!master_req) begin
                        // Master withdrew before L2 could act: abort, pointer untouched.
                        state_reg   <= IDLE;
                        bus_control <= '0;
                        bus_en      <= 1'b0;
                        curr_master <= '0;
                    end else begin
                        state_reg   <= WAIT_L2;
                        bus_control <= CTRL_W'(MEM_PORT);
                        bus_en      <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        wd_cnt_reg  <= '0;
`endif
                    end
                end
                WAIT_L2: begin
                    if (l2_done) begin
                        state_reg   <= RELEASE;
                        bus_control <= '0;
                        bus_en      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                    end else if (wd_cnt_reg == TIMEOUT_LAST) begin
                        state_reg       <= RELEASE;
                        bus_control     <= '0;
                        bus_en          <= 1'b0;
                        timeout_err_reg <= 1'b1;
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + 16'd1;
`endif
                    end
                end
                RELEASE: begin
                    if (!master_req) begin
                        state_reg   <= IDLE;
                        curr_master <= '0;
                        rr_ptr_reg  <= next_ptr;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Randomized scoreboard bench for coherence_bus_arbiter (N=4, TIMEOUT_CYCLES=8).
// A transaction-level model predicts each cycle's outputs and every grant;
// a negedge monitor pops and compares them.
module tb_coherence_bus_arbiter;

    localparam int N    = 4;
    localparam int MB   = 4;
    localparam int DONE = 9;
    localparam int TMO  = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N*MB-1:0] cache2bus_msg = '0;
    logic [MB-1:0]   l2_msg = '0;
    logic [2:0]      bus_control;
    logic            bus_en;
    logic [N-1:0]    curr_master;
    logic            req_ready;
    logic            timeout_err;

    coherence_bus_arbiter #(
        .NUM_CACHES(N), .MSG_BITS(MB), .NO_REQ(4'd0), .DONE_MSG(4'd9), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset(reset), .cache2bus_msg(cache2bus_msg), .l2_msg(l2_msg),
        .bus_control(bus_control), .bus_en(bus_en), .curr_master(curr_master),
        .req_ready(req_ready), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]   ctrl;
        logic         en;
        logic [N-1:0] master;
        logic         rdy;
        logic         terr;
    } exp_t;

    exp_t exp_q[$];
    int   grant_q[$];
    int   checks = 0;
    int   failures = 0;

    // Transaction-level model: who owns the bus and which phase it is in.
    // phase 0 = free, 1 = request presented, 2 = L2 working, 3 = awaiting withdrawal
    int m_phase, m_owner, m_ptr, m_cnt;
    bit m_terr, m_granted_now;

    function automatic int msg_of(int i);
        return int'(cache2bus_msg[i*MB +: MB]);
    endfunction

    task automatic set_msg(int i, int v);
        cache2bus_msg[i*MB +: MB] = 4'(v);
    endtask

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_terr = 0;
    endtask

    function automatic exp_t expected();
        exp_t e;
        e.en     = (m_phase == 1 || m_phase == 2);
        e.rdy    = (m_phase == 1);
        e.master = (m_phase == 0) ? '0 : N'(1 << m_owner);
        e.ctrl   = (m_phase == 1) ? 3'(m_owner) : (m_phase == 2) ? 3'(N) : 3'd0;
        e.terr   = m_terr;
        return e;
    endfunction

    task automatic model_step();
        m_granted_now = 0;
        if (reset) begin
            model_reset();
            return;
        end
        case (m_phase)
            0: begin
                for (int k = 0; k < N; k++) begin
                    automatic int i = (m_ptr + k) % N;
                    if (msg_of(i) != 0) begin
                        m_phase = 1; m_owner = i;
                        grant_q.push_back(i); m_granted_now = 1;
                        break;
                    end
                end
            end
            1: begin
                if (msg_of(m_owner) == 0) m_phase = 0;
                else begin m_phase = 2; m_cnt = 0; end
            end
            2: begin
                if (int'(l2_msg) == DONE) m_phase = 3;
`ifdef ARB_TIMEOUT_EN
                else if (m_cnt == TMO - 1) begin m_phase = 3; m_terr = 1; end
                else m_cnt++;
`endif
            end
            default: begin
                if (msg_of(m_owner) == 0) begin
                    m_phase = 0; m_ptr = (m_owner + 1) % N;
                end
            end
        endcase
    endtask

    // One clock: model consumes the inputs the DUT samples, expectation queued.
    task automatic tick();
        @(posedge clock);
        model_step();
        exp_q.push_back(expected());
        #1;
    endtask

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: compare each cycle's outputs and every presented request.
    exp_t e_mon;
    int   g_mon;
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            checks++;
            if (bus_control !== e_mon.ctrl || bus_en !== e_mon.en || curr_master !== e_mon.master ||
                req_ready !== e_mon.rdy || timeout_err !== e_mon.terr) begin
                failures++;
                $display("FAIL outputs t=%0t bus_control=%0d/%0d bus_en=%0b/%0b curr_master=%b/%b req_ready=%0b/%0b timeout_err=%0b/%0b (actual/required)",
                         $time, bus_control, e_mon.ctrl, bus_en, e_mon.en, curr_master, e_mon.master,
                         req_ready, e_mon.rdy, timeout_err, e_mon.terr);
            end
            if (req_ready === 1'b1) begin
                checks++;
                if (grant_q.size() == 0) begin
                    failures++;
                    $display("FAIL grant_order unexpected grant to %0d", bus_control);
                end else begin
                    g_mon = grant_q.pop_front();
                    if (int'(bus_control) != g_mon) begin
                        failures++;
                        $display("FAIL grant_order actual=%0d required=%0d", bus_control, g_mon);
                    end
                end
            end
        end
    end

    // Serve whatever is pending: L2 completes promptly, master withdraws in release.
    task automatic run_until_idle(int budget);
        int n = 0;
        while (!(m_phase == 0 && cache2bus_msg == '0)) begin
            if (n >= budget) begin
                check("idle_budget", n, -1);
                return;
            end
            l2_msg = (m_phase == 2) ? 4'(DONE) : 4'd0;
            if (m_phase == 3) set_msg(m_owner, 0);
            tick();
            n++;
        end
        l2_msg = '0;
    endtask

    // Asynchronous reset pulse raised mid-cycle; outputs must clear at once.
    task automatic reset_pulse();
        reset = 1'b1;
        if (m_granted_now) void'(grant_q.pop_back());
        model_reset();
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        exp_q.push_back(expected());
        #1;
        check("async_rst_bus_en", int'(bus_en), 0);
        check("async_rst_curr_master", int'(curr_master), 0);
        check("async_rst_req_ready", int'(req_ready), 0);
        check("async_rst_timeout_err", int'(timeout_err), 0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("reset_bus_control", int'(bus_control), 0);
        check("reset_bus_en", int'(bus_en), 0);
        check("reset_curr_master", int'(curr_master), 0);
        check("reset_req_ready", int'(req_ready), 0);
        check("reset_timeout_err", int'(timeout_err), 0);
        reset = 1'b0;

        // Lone requester 2, then L2 done, master holds 3 cycles in release.
        set_msg(2, 1);
        tick(); tick();
        l2_msg = 4'(DONE);
        tick();
        l2_msg = '0;
        repeat (3) tick();
        set_msg(2, 0);
        tick(); tick();

        // Cache 1 aborts during its request cycle, then is granted next.
        set_msg(1, 1);
        tick();
        set_msg(1, 0);
        tick(); tick();
        set_msg(1, 6);
        run_until_idle(40);

        // Three simultaneous holders from pointer 0 are served 0, 1, 3.
        reset_pulse();
        set_msg(0, 1); set_msg(1, 1); set_msg(3, 1);
        run_until_idle(60);

        // L2 never answers: watchdog (if built) or indefinite wait.
        set_msg(0, 3);
        l2_msg = '0;
        repeat (15) tick();
        run_until_idle(40);

        // Randomized traffic with held, changing and withdrawn requests.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (msg_of(i) == 0) begin
                    if ($urandom_range(0, 3) == 0) set_msg(i, int'($urandom_range(1, 15)));
                end else if ($urandom_range(0, 7) == 0) begin
                    set_msg(i, 0);
                end
            end
            l2_msg = ($urandom_range(0, 4) == 0) ? 4'(DONE) : 4'($urandom_range(0, 15));
            tick();
        end

        // Reset during WAIT_L2 abandons the transaction.
        cache2bus_msg = '0;
        run_until_idle(40);
        set_msg(2, 7);
        l2_msg = '0;
        for (int n = 0; n < 10 && m_phase != 2; n++) tick();
        check("reach_wait_l2", m_phase, 2);
        tick();
        reset_pulse();
        cache2bus_msg = '0;
        repeat (3) tick();

        @(negedge clock);
        #1;
        check("grants_all_seen", grant_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
